// File: rtl/maxnet_seq.sv
// maxnet_seq: sequencer for a time-multiplexed Maxnet datapath.
// A single shared MAC computes the next activation one neuron at a time.
// This block steps row/col through CLR -> MAC x N -> WB for every row,
// commits the iteration in UPDATE, and tests nz_cnt_i for convergence in CHECK.
// Optional feature macro: MAXNET_SEQ_TIMEOUT_EN. It stops at iter == MAX_ITER
// and flags timeout_o. Without it the block runs until convergence.
module maxnet_seq #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_W    = $clog2(N),
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [IDX_W:0]    nz_cnt_i,
  output logic              load_x_o,
  output logic              load_t_o,
  output logic              sel_init_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic              wr_en_o,
  output logic [IDX_W-1:0]  row_o,
  output logic [IDX_W-1:0]  col_o,
  output logic [ITER_W-1:0] iter_o,
  output logic              busy_o,
  output logic              done_o
`ifdef MAXNET_SEQ_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  // Reject parameter sets the counters cannot represent.
  if (N < 2 || (64'(1) << ITER_W) <= 64'(MAX_ITER)) begin : g_bad_param
    $error("maxnet_seq: need N >= 2 and 2**ITER_W > MAX_ITER");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CLR,
    S_MAC,
    S_WB,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    row_q, row_d;
  logic [IDX_W-1:0]    col_q, col_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                converged;

  assign converged = (nz_cnt_i <= (IDX_W + 1)'(1));

`ifdef MAXNET_SEQ_TIMEOUT_EN
  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);
  logic to_q, to_d;
`endif

  // State and counter registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      iter_q  <= '0;
`ifdef MAXNET_SEQ_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      iter_q  <= iter_d;
`ifdef MAXNET_SEQ_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  // Next-state and counter update; col is zeroed on every entry to CLR so it
  // reads 0 there and never wraps past N-1 in MAC.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    iter_d  = iter_q;
`ifdef MAXNET_SEQ_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_INIT;
      end
      S_INIT: begin
        iter_d = '0;
`ifdef MAXNET_SEQ_TIMEOUT_EN
        to_d   = 1'b0;
`endif
        if (!start_i) begin
          state_d = S_CLR;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_CLR: begin
        col_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (col_q == LAST_IDX) state_d = S_WB;
        else                   col_d   = col_q + IDX_W'(1);
      end
      S_WB: begin
        if (row_q == LAST_IDX) begin
          state_d = S_UPDATE;
        end else begin
          row_d   = row_q + IDX_W'(1);
          col_d   = '0;
          state_d = S_CLR;
        end
      end
      S_UPDATE: begin
        iter_d  = iter_q + ITER_W'(1);
        state_d = S_CHECK;
      end
      S_CHECK: begin
`ifdef MAXNET_SEQ_TIMEOUT_EN
        if (converged) begin
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (iter_q == ITER_CAP) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_CLR;
        end
`else
        if (converged) begin
          state_d = S_DONE;
        end else begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_CLR;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode of the current state and counters.
  assign load_x_o   = (state_q == S_INIT);
  assign load_t_o   = (state_q == S_INIT) || (state_q == S_UPDATE);
  assign sel_init_o = (state_q == S_INIT);
  assign acc_clr_o  = (state_q == S_CLR);
  assign acc_en_o   = (state_q == S_MAC);
  assign wr_en_o    = (state_q == S_WB);
  assign row_o      = row_q;
  assign col_o      = col_q;
  assign iter_o     = iter_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
`ifdef MAXNET_SEQ_TIMEOUT_EN
  assign timeout_o  = (state_q == S_DONE) && to_q;
`endif

endmodule

// File: tb/tb_maxnet_seq.sv
// Directed bench for maxnet_seq with N=4.
module tb_maxnet_seq;

`ifdef MAXNET_SEQ_TIMEOUT_EN
  localparam int unsigned MAX_ITER_TB = 2;
`else
  localparam int unsigned MAX_ITER_TB = 15;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] nz;
  logic       load_x, load_t, sel_init, acc_clr, acc_en, wr_en, busy, done;
  logic [1:0] row, col;
  logic [3:0] iter;
`ifdef MAXNET_SEQ_TIMEOUT_EN
  logic       timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  maxnet_seq #(.N(4), .IDX_W(2), .MAX_ITER(MAX_ITER_TB), .ITER_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .nz_cnt_i   (nz),
    .load_x_o   (load_x),
    .load_t_o   (load_t),
    .sel_init_o (sel_init),
    .acc_clr_o  (acc_clr),
    .acc_en_o   (acc_en),
    .wr_en_o    (wr_en),
    .row_o      (row),
    .col_o      (col),
    .iter_o     (iter),
    .busy_o     (busy),
    .done_o     (done)
`ifdef MAXNET_SEQ_TIMEOUT_EN
    ,
    .timeout_o  (timeout)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; nz = 3'd0;
    tick(); tick();
    n_tests++;
    if ({load_x, load_t, sel_init, acc_clr, acc_en, wr_en, busy, done} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 00000000",
               {load_x, load_t, sel_init, acc_clr, acc_en, wr_en, busy, done});
    end
    n_tests++;
    if ({row, col, iter} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_counters: got %h expected 00", {row, col, iter});
    end
    rst = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({busy, done, load_x, acc_clr} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got %b expected 0000", {busy, done, load_x, acc_clr});
    end
  endtask

  // One start pulse, one iteration, every cycle checked against the schedule.
  task automatic test_single();
    logic [11:0] act, exp;
    int r, p;
    nz = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if ({load_x, load_t, sel_init, busy, iter} !== {4'b1111, 4'd0}) begin
      n_fail++;
      $display("FAIL single_init: got %b expected 11110000", {load_x, load_t, sel_init, busy, iter});
    end
    for (int c = 1; c <= 24; c++) begin
      tick();
      r = (c - 1) / 6;
      p = (c - 1) % 6;
      exp = {3'b000, (p == 0), (p >= 1 && p <= 4), (p == 5), 2'(r),
             (p == 0) ? 2'd0 : ((p == 5) ? 2'd3 : 2'(p - 1)), 1'b1, 1'b0};
      act = {load_x, load_t, sel_init, acc_clr, acc_en, wr_en, row, col, busy, done};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL single_cycle%0d: got %b expected %b", c, act, exp);
      end
    end
    tick();
    n_tests++;
    if ({load_x, load_t, sel_init, acc_en, wr_en, iter} !== {5'b01000, 4'd0}) begin
      n_fail++;
      $display("FAIL single_update: got %b expected 010000000", {load_x, load_t, sel_init, acc_en, wr_en, iter});
    end
    tick();
    n_tests++;
    if ({busy, done, load_t, iter} !== {3'b100, 4'd1}) begin
      n_fail++;
      $display("FAIL single_check: got %b expected 1000001", {busy, done, load_t, iter});
    end
    tick();
    n_tests++;
    if ({busy, done, iter} !== {2'b11, 4'd1}) begin
      n_fail++;
      $display("FAIL single_done: got %b expected 110001", {busy, done, iter});
    end
    tick();
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_held_start();
    bit seen = 1'b0;
    nz = 3'd1; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++;
      if ({load_x, sel_init, acc_clr} !== 3'b110) begin
        n_fail++;
        $display("FAIL held_init%0d: got %b expected 110", k, {load_x, sel_init, acc_clr});
      end
    end
    start = 1'b0;
    tick();
    n_tests++;
    if ({load_x, acc_clr, row, col} !== 6'b010000) begin
      n_fail++;
      $display("FAIL held_first_clr: got %b expected 010000", {load_x, acc_clr, row, col});
    end
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    n_tests++;
    if (!seen || iter !== 4'd1) begin
      n_fail++;
      $display("FAIL held_done: got seen=%0d iter=%0d expected seen=1 iter=1", seen, iter);
    end
    tick();
  endtask

  // nz_cnt follows a per-iteration list, updated right after each UPDATE cycle.
  task automatic run_nz_list(input int n_iter, input logic [2:0] hi, input logic [2:0] lo,
                             output int wr, output int lt, output bit seen, output logic [3:0] it);
    wr = 0; lt = 0; seen = 1'b0; it = '0;
    nz = hi; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      tick();
      if (wr_en) wr++;
      if (load_t && !sel_init) begin
        lt++;
        nz = (lt >= n_iter) ? lo : hi;
      end
      if (done) begin
        seen = 1'b1;
        it = iter;
      end
    end
  endtask

`ifndef MAXNET_SEQ_TIMEOUT_EN
  task automatic test_multi();
    int wr, lt;
    bit seen;
    logic [3:0] it;
    run_nz_list(3, 3'd3, 3'd1, wr, lt, seen, it);
    n_tests++;
    if (!seen || it !== 4'd3) begin
      n_fail++;
      $display("FAIL multi_iter: got seen=%0d iter=%0d expected seen=1 iter=3", seen, it);
    end
    n_tests++;
    if (wr != 12 || lt != 3) begin
      n_fail++;
      $display("FAIL multi_pulses: got wr=%0d lt=%0d expected wr=12 lt=3", wr, lt);
    end
    tick();
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL multi_idle: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_iter_wrap();
    int wr, lt;
    bit seen;
    logic [3:0] it;
    run_nz_list(17, 3'd4, 3'd1, wr, lt, seen, it);
    n_tests++;
    if (!seen || it !== 4'd1 || lt != 17) begin
      n_fail++;
      $display("FAIL iter_wrap: got seen=%0d iter=%0d lt=%0d expected seen=1 iter=1 lt=17", seen, it, lt);
    end
    tick();
  endtask
`else
  task automatic test_timeout();
    int wr, lt;
    bit seen;
    logic [3:0] it;
    run_nz_list(99, 3'd4, 3'd4, wr, lt, seen, it);
    n_tests++;
    if (!seen || it !== 4'd2 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_hit: got seen=%0d iter=%0d to=%b expected 1 2 1", seen, it, timeout);
    end
    tick();
    n_tests++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b expected 0", timeout);
    end
    run_nz_list(2, 3'd4, 3'd1, wr, lt, seen, it);
    n_tests++;
    if (!seen || it !== 4'd2 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_conv_wins: got seen=%0d iter=%0d to=%b expected 1 2 0", seen, it, timeout);
    end
    tick();
  endtask
`endif

  task automatic test_all_zero();
    int wr, lt;
    bit seen;
    logic [3:0] it;
    run_nz_list(1, 3'd0, 3'd0, wr, lt, seen, it);
    n_tests++;
    if (!seen || it !== 4'd1 || wr != 4) begin
      n_fail++;
      $display("FAIL all_zero: got seen=%0d iter=%0d wr=%0d expected 1 1 4", seen, it, wr);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    bit seen = 1'b0;
    int lat = 0;
    nz = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick();
      if (acc_en && row == 2'd2) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL midrst_reach: got found=0 expected found=1");
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({load_x, load_t, sel_init, acc_clr, acc_en, wr_en, busy, done, row, col, iter} !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrst_zero: got %h expected 0000",
               {load_x, load_t, sel_init, acc_clr, acc_en, wr_en, busy, done, row, col, iter});
    end
    rst = 1'b0;
    nz = 3'd1;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: got busy=%b expected 0", busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      tick();
      lat++;
      if (done) seen = 1'b1;
    end
    n_tests++;
    if (!seen || lat != 27 || iter !== 4'd1) begin
      n_fail++;
      $display("FAIL midrst_rerun: got seen=%0d lat=%0d iter=%0d expected 1 27 1", seen, lat, iter);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_held_start();
`ifndef MAXNET_SEQ_TIMEOUT_EN
    test_multi();
    test_iter_wrap();
`else
    test_timeout();
`endif
    test_all_zero();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
